// File: rtl/vend_pkg.sv
// Definitions shared by the vending FSM and the change dispenser: change codes,
// coin input codes, the dispenser state type and the layout of a queued job.
package vend_pkg;

   localparam logic [2:0] CH_0  = 3'b000;
   localparam logic [2:0] CH_5  = 3'b001;
   localparam logic [2:0] CH_10 = 3'b010;
   localparam logic [2:0] CH_15 = 3'b011;
   localparam logic [2:0] CH_20 = 3'b100;

   localparam logic [1:0] IN_5  = 2'b01;
   localparam logic [1:0] IN_10 = 2'b10;

   localparam int AMT_W = 3;
   localparam int JOB_W = AMT_W + 1;

   // amount counts Rs.5 units, 0..4
   typedef struct packed {
      logic             vend;
      logic [AMT_W-1:0] amount;
   } job_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VEND,
      ST_PAY10,
      ST_PAY5,
      ST_GAP
   } disp_state_e;

   function automatic logic is_legal_change(input logic [2:0] code);
      return code <= CH_20;
   endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job FIFO with registered occupancy count. A push while full is
// accepted when a pop happens on the same edge.
module job_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Queues vend/change events from the vending FSM and runs them one at a time
// against the product motor and the Rs.10 / Rs.5 coin hoppers.
//
// state  | meaning
// IDLE   | no job; pops the next queued job when the FIFO is non-empty
// VEND   | motor_req held until motor_ack or timeout
// PAY10  | coin10_req held until coin10_ack or timeout
// PAY5   | coin5_req held until coin5_ack or timeout
// GAP    | one cycle with every req low so the actuator can re-arm
module change_dispenser
   import vend_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vend_in,
   input  logic [2:0]                change_in,
   output logic                      motor_req,
   input  logic                      motor_ack,
   output logic                      coin10_req,
   input  logic                      coin10_ack,
   output logic                      coin5_req,
   input  logic                      coin5_ack,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      overflow,
   output logic                      illegal,
   output logic                      fault,
   input  logic                      clr_flags
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   disp_state_e      state_q;
   logic [AMT_W-1:0] amt_q;
   logic [TMO_W-1:0] tmo_q;
   logic             motor_req_q;
   logic             coin10_req_q;
   logic             coin5_req_q;
   logic             overflow_q;
   logic             illegal_q;
   logic             fault_q;

   job_t cap_job;
   job_t head_job;
   logic chg_legal;
   logic cap_push;
   logic pop;
   logic fifo_full;
   logic fifo_empty;
   logic ovf_evt;

   always_comb begin
      chg_legal      = is_legal_change(change_in);
      cap_job.vend   = vend_in;
      cap_job.amount = chg_legal ? change_in : CH_0;
      cap_push       = vend_in | (chg_legal & (change_in != CH_0));
      pop            = (state_q == ST_IDLE) & ~fifo_empty;
      ovf_evt        = cap_push & fifo_full & ~pop;
   end

   job_fifo #(
      .WIDTH (JOB_W),
      .DEPTH (DEPTH)
   ) u_job_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cap_push),
      .pop_i   (pop),
      .din_i   (cap_job),
      .dout_o  (head_job),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         amt_q        <= '0;
         tmo_q        <= '0;
         motor_req_q  <= 1'b0;
         coin10_req_q <= 1'b0;
         coin5_req_q  <= 1'b0;
         overflow_q   <= 1'b0;
         illegal_q    <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         // a flag event on the same edge as clr_flags keeps the flag set
         if (clr_flags) begin
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
         end
         if (!chg_legal) illegal_q  <= 1'b1;
         if (ovf_evt)    overflow_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               tmo_q <= '0;
               if (!fifo_empty) begin
                  amt_q <= head_job.amount;
                  if (head_job.vend) begin
                     motor_req_q <= 1'b1;
                     state_q     <= ST_VEND;
                  end else if (head_job.amount >= AMT_W'(2)) begin
                     coin10_req_q <= 1'b1;
                     state_q      <= ST_PAY10;
                  end else if (head_job.amount == AMT_W'(1)) begin
                     coin5_req_q <= 1'b1;
                     state_q     <= ST_PAY5;
                  end
               end
            end
            ST_VEND: begin
               if (motor_ack) begin
                  motor_req_q <= 1'b0;
                  state_q     <= ST_GAP;
               end else if (tmo_q == TMO_LAST) begin
                  motor_req_q <= 1'b0;
                  fault_q     <= 1'b1;
                  amt_q       <= '0;
                  state_q     <= ST_GAP;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            ST_PAY10: begin
               if (coin10_ack) begin
                  coin10_req_q <= 1'b0;
                  amt_q        <= amt_q - AMT_W'(2);
                  state_q      <= ST_GAP;
               end else if (tmo_q == TMO_LAST) begin
                  coin10_req_q <= 1'b0;
                  fault_q      <= 1'b1;
                  amt_q        <= '0;
                  state_q      <= ST_GAP;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            ST_PAY5: begin
               if (coin5_ack) begin
                  coin5_req_q <= 1'b0;
                  amt_q       <= amt_q - AMT_W'(1);
                  state_q     <= ST_GAP;
               end else if (tmo_q == TMO_LAST) begin
                  coin5_req_q <= 1'b0;
                  fault_q     <= 1'b1;
                  amt_q       <= '0;
                  state_q     <= ST_GAP;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            ST_GAP: begin
               tmo_q <= '0;
               if (amt_q >= AMT_W'(2)) begin
                  coin10_req_q <= 1'b1;
                  state_q      <= ST_PAY10;
               end else if (amt_q == AMT_W'(1)) begin
                  coin5_req_q <= 1'b1;
                  state_q     <= ST_PAY5;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign motor_req  = motor_req_q;
   assign coin10_req = coin10_req_q;
   assign coin5_req  = coin5_req_q;
   assign overflow   = overflow_q;
   assign illegal    = illegal_q;
   assign fault      = fault_q;
   assign busy       = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending FSM. Consumes its registered `out` (vend) and `change` (Rs.5-unit code) outputs.
- Queues each non-zero event as a dispense job and executes jobs one at a time. Each job first drives the product motor, then pays change with Rs.10 and Rs.5 coin hoppers over req/ack handshakes.
- Decouples the single-cycle FSM outputs from slow electromechanical actuators.

Parameters:
- DEPTH, 4, job FIFO entries (power of two, ≥2).
- TIMEOUT, 1000, max cycles any req may wait for its ack before fault.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- vend_in  input  1  product dispense request from the vending FSM (`out`)
- change_in  input  3  change code: 000=Rs.0, 001=5, 010=10, 011=15, 100=20; 101–111 illegal
- motor_req  output  1  product motor request, held until motor_ack
- motor_ack  input  1  product delivered
- coin10_req  output  1  Rs.10 hopper request, held until coin10_ack
- coin10_ack  input  1  one Rs.10 coin ejected
- coin5_req  output  1  Rs.5 hopper request, held until coin5_ack
- coin5_ack  input  1  one Rs.5 coin ejected
- busy  output  1  job active or FIFO non-empty
- fifo_count  output  $clog2(DEPTH)+1  queued jobs
- overflow  output  1  sticky: job dropped because FIFO full
- illegal  output  1  sticky: change_in code 101–111 seen
- fault  output  1  sticky: handshake timeout occurred
- clr_flags  input  1  clears overflow/illegal/fault next cycle

Behaviour:
- All outputs are registered. Reset value of every output is 0; FIFO is emptied, FSM goes to IDLE, timeout counter is cleared.
- Reset mid-operation aborts the job. All reqs drop the cycle after the reset edge; queued jobs are lost.
- Capture: at each edge, if vend_in=1 or change_in≠000, push job {vend, amount}. Amount is in Rs.5 units (0–4).
- Illegal change code: set illegal, force amount=0. Still push if vend_in=1; otherwise nothing is pushed.
- FIFO full with push: drop the new job and set overflow. Exception: a pop on the same edge frees a slot, so the push succeeds (no overflow).
- FSM states: IDLE, VEND, PAY10, PAY5, GAP.
- IDLE: when FIFO non-empty, pop into the job register, then:
  - vend=1 → VEND;
  - else amount≥2 → PAY10;
  - else amount=1 → PAY5;
  - else back to IDLE (an empty job cannot occur).
- Latency: job sampled at edge E0, popped at E1. The first req is high in the cycle after E1. This gives 2 cycles from input to req.
- VEND: motor_req=1. When motor_ack=1 is sampled with req high: deassert req, go to GAP.
- PAY10: coin10_req=1. On ack: amount-=2, go to GAP.
- PAY5: coin5_req=1. On ack: amount-=1, go to GAP.
- GAP: all reqs low for exactly one cycle (hopper re-arm). Then:
  - amount≥2 → PAY10;
  - amount=1 → PAY5;
  - amount=0 → IDLE.
- Greedy payout: Rs.10 coins first, then Rs.5. For example, 15 → one Rs.10 then one Rs.5; 20 → two Rs.10.
- Acks seen while the corresponding req is low are ignored.
- Timeout: a counter resets on entering any req state and increments each cycle the req is high without ack. When it reaches TIMEOUT: set fault, drop req, discard the rest of the job, go to GAP→IDLE. The next job then proceeds normally.
- fifo_count reflects pushes and pops of the previous edge.
- busy = (state≠IDLE) | (fifo_count≠0).
- clr_flags and a simultaneous new flag event on the same edge: the new event wins (flag stays set).

Decomposition:
- Shared package vend_pkg:
  - change-code constants CH_0..CH_20 (3'b000–3'b100), also to be adopted by the vending FSM;
  - coin-input constants IN_5=2'b01, IN_10=2'b10;
  - state typedef/localparams for this block;
  - job-record width helpers.
- Sub-module job_fifo: synchronous FIFO, params WIDTH/DEPTH, push/pop/full/empty/count, same-edge push+pop legal when full.
- The dispense FSM stays in change_dispenser.

Test Plan:
- change_in=011 for one cycle, acks 3 cycles after each req → coin10_req then coin5_req, one GAP cycle between; motor_req never rises; busy drops after the last GAP.
- vend_in=1 with change_in=001 in the same cycle → motor_req at cycle +2; after motor_ack, GAP, then one coin5_req; exactly one Rs.5 paid.
- Hold all acks low, push 5 jobs (change=001) on consecutive cycles, DEPTH=4:
  - job 1 pops at E1, so jobs 2–5 fill the FIFO and no job is dropped;
  - a 6th push → overflow=1, fifo_count stays 4.
- change_in=101 with vend_in=0 → illegal=1, nothing queued. Then assert clr_flags → illegal=0 on the next cycle.
- change_in=100, coin10_ack never returned, TIMEOUT=16:
  - fault=1 after 16 req cycles, coin10_req drops, FSM returns to IDLE;
  - a following change=001 job is still paid correctly.
- rst asserted while coin10_req is high with 2 jobs queued → the cycle after the reset edge, all outputs are 0 and fifo_count=0.
